// File: rtl/booth_seq_divider_pkg.sv
// Shared arithmetic package for the sequential Booth multiplier / divider pair.
//
// Contents:
//   state_e     FSM state encoding used by the sequential datapaths
//   clog2()     ceiling log2, used to size iteration counters (clog2(N+1))
//   twos_neg()  two's-complement negate on a 32-bit container
//   twos_abs()  magnitude of a two's-complement value given its sign bit
//
// Users zero-extend an N-bit operand to 32 bits, call the helper, and
// truncate the result back to N bits. Negation is correct modulo 2^N, so the
// N-bit slice of the 32-bit result is the N-bit answer for any N <= 32.
package booth_seq_divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int HELPER_W = 32;

  // Number of bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return result;
  endfunction

  function automatic logic [HELPER_W-1:0] twos_neg(input logic [HELPER_W-1:0] a);
    return ~a + 32'd1;
  endfunction

  // The most negative N-bit value maps onto 2^(N-1), which is still
  // representable as an N-bit unsigned magnitude.
  function automatic logic [HELPER_W-1:0] twos_abs(input logic [HELPER_W-1:0] a,
                                                   input logic is_neg);
    return is_neg ? twos_neg(a) : a;
  endfunction

endpackage

// File: rtl/booth_seq_divider_if.sv
// Handshake and data bundle of the sequential divider.
//
// Signals (N = operand width):
//   start  request, sampled by the divider only while idle
//   X, Y   signed dividend / divisor, captured on acceptance
//   valid  one-cycle pulse when Q/R/ovf/dz are updated
//   busy   high while an accepted operation is in progress
//   Q, R   signed quotient / remainder
//   ovf    -2^(N-1) / -1 overflow flag
//   dz     divide-by-zero flag
//
// Modports: master drives requests (arithmetic unit side), slave is the divider.
interface booth_seq_divider_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] X;
  logic [N-1:0] Y;
  logic         valid;
  logic         busy;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         ovf;
  logic         dz;

  modport master (
    output start, X, Y,
    input  valid, busy, Q, R, ovf, dz
  );

  modport slave (
    input  start, X, Y,
    output valid, busy, Q, R, ovf, dz
  );

endinterface

// File: rtl/booth_div_step.sv
// One restoring-division iteration, purely combinational.
//
// Ports:
//   rem_in   (N+1) partial remainder before this step
//   bit_in   next dividend bit (MSB first)
//   divisor  N-bit unsigned divisor magnitude
//   rem_out  (N+1) partial remainder after this step
//   q_bit    quotient bit produced by this step
//
// The shifted remainder is held one bit wider than rem_in so the compare
// against the divisor never overflows, including the divide-by-zero case
// where the remainder simply accumulates the dividend.
module booth_div_step #(
  parameter int N = 4
) (
  input  logic [N:0]   rem_in,
  input  logic         bit_in,
  input  logic [N-1:0] divisor,
  output logic [N:0]   rem_out,
  output logic         q_bit
);

  localparam int W_SH  = N + 2;
  localparam int W_REM = N + 1;

  logic [W_SH-1:0] shifted;
  logic [W_SH-1:0] div_ext;

  always_comb begin
    shifted = {rem_in, bit_in};
    div_ext = {2'b00, divisor};
    // trial >= 0 is the same as shifted >= divisor; keep the difference,
    // otherwise restore by passing the shifted remainder through.
    q_bit   = (shifted >= div_ext);
    rem_out = q_bit ? W_REM'(shifted - div_ext) : shifted[N:0];
  end

endmodule

// File: rtl/booth_seq_divider.sv
// Sequential signed integer divider, one restoring step per clock.
//
// Computes Q = X / Y truncated toward zero and R = X - Q*Y (R takes the sign
// of X). Operands are converted to magnitudes on acceptance, divided as
// unsigned numbers over N CALC cycles, and the signs are reapplied in DONE.
// -2^(N-1) / -1 wraps to Q = -2^(N-1), R = 0 and raises ovf.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-low reset
//   bus    booth_seq_divider_if slave modport (start/X/Y in; valid/busy/Q/R/ovf/dz out)
//
// Latency: start sampled at edge 0, valid high after edge N+1.
//
// Configuration macro BOOTH_DIV_DZ_DETECT_EN:
//   defined   Y = 0 is caught on acceptance, CALC is skipped, result is
//             Q = 0, R = X, dz = 1 with valid after edge 1.
//   undefined dz stays 0 and the full sequence runs, which yields
//             Q = (X<0) ? 1 : -1 and R = X.
module booth_seq_divider
  import booth_seq_divider_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  booth_seq_divider_if.slave    bus
);

  localparam int               CNT_W    = clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
  localparam logic [N-1:0]     MIN_VAL  = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]     NEG_ONE  = {N{1'b1}};

  // N-bit two's-complement negate built on the shared helper.
  function automatic logic [N-1:0] neg_n(input logic [N-1:0] a);
    return N'(twos_neg(32'(a)));
  endfunction

  state_e           state_q, state_d;
  // Dividend magnitude shifts out MSB-first while quotient bits shift in at
  // the LSB, so after N steps this register holds the quotient magnitude.
  logic [N-1:0]     dvd_q, dvd_d;
  logic [N-1:0]     dvs_q, dvs_d;
  logic [N:0]       rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sx_q, sx_d;
  logic             sy_q, sy_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             dz_pend_q, dz_pend_d;

  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [N-1:0]     quo_q, quo_d;
  logic [N-1:0]     rmd_q, rmd_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;

  logic [N-1:0]     x_mag;
  logic [N-1:0]     y_mag;
  logic [N:0]       step_rem;
  logic             step_q;
  logic [N-1:0]     rem_mag;

  booth_div_step #(
    .N (N)
  ) u_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[N-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    x_mag = N'(twos_abs(32'(bus.X), bus.X[N-1]));
    y_mag = N'(twos_abs(32'(bus.Y), bus.Y[N-1]));
  end

  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    ovf_pend_d = ovf_pend_q;
    dz_pend_d  = dz_pend_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    quo_d      = quo_q;
    rmd_d      = rmd_q;
    ovf_d      = ovf_q;
    dz_d       = dz_q;
    // On a detected divide-by-zero the dividend register was never shifted,
    // so it still holds |X| and is used as the remainder magnitude.
    rem_mag    = dz_pend_q ? dvd_q : rem_q[N-1:0];

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dvd_d      = x_mag;
          dvs_d      = y_mag;
          sx_d       = bus.X[N-1];
          sy_d       = bus.Y[N-1];
          rem_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = (bus.X == MIN_VAL) && (bus.Y == NEG_ONE);
          busy_d     = 1'b1;
`ifdef BOOTH_DIV_DZ_DETECT_EN
          dz_pend_d  = (bus.Y == '0);
          state_d    = (bus.Y == '0) ? S_DONE : S_CALC;
`else
          dz_pend_d  = 1'b0;
          state_d    = S_CALC;
`endif
        end
      end

      S_CALC: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[N-2:0], step_q};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        ovf_d   = ovf_pend_q;
        dz_d    = dz_pend_q;
        rmd_d   = sx_q ? neg_n(rem_mag) : rem_mag;
        if (dz_pend_q) begin
          quo_d = '0;
        end else begin
          quo_d = (sx_q ^ sy_q) ? neg_n(dvd_q) : dvd_q;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      sx_q       <= 1'b0;
      sy_q       <= 1'b0;
      ovf_pend_q <= 1'b0;
      dz_pend_q  <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      quo_q      <= '0;
      rmd_q      <= '0;
      ovf_q      <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      ovf_pend_q <= ovf_pend_d;
      dz_pend_q  <= dz_pend_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      quo_q      <= quo_d;
      rmd_q      <= rmd_d;
      ovf_q      <= ovf_d;
      dz_q       <= dz_d;
    end
  end

  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.Q     = quo_q;
  assign bus.R     = rmd_q;
  assign bus.ovf   = ovf_q;
  assign bus.dz    = dz_q;

endmodule

// File: tb/tb_booth_seq_divider.sv
// Testbench for booth_seq_divider (N = 4).
// Directed vector table, hand-written multi-cycle sequences (start while
// busy, reset mid-operation, back-to-back), then random operands checked
// against an integer-arithmetic reference model. Honours
// BOOTH_DIV_DZ_DETECT_EN for the divide-by-zero expectations.
module tb_booth_seq_divider;

  localparam int N         = 4;
  localparam int WAIT_MAX  = 20;
  localparam int N_RANDOM  = 60;

  typedef struct {
    int x;
    int y;
    int q;
    int r;
    int ovf;
    int dz;
    int lat;
  } vec_t;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  booth_seq_divider_if #(.N(N)) bus ();

  booth_seq_divider #(
    .N (N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  // Reference: plain signed integer division, with the wrap and
  // divide-by-zero behaviour layered on top.
  task automatic refModel(input int x, input int y, output int q, output int r,
                          output int ovf, output int dz, output int lat);
    ovf = 0;
    dz  = 0;
    lat = N + 1;
    if (y == 0) begin
`ifdef BOOTH_DIV_DZ_DETECT_EN
      q   = 0;
      dz  = 1;
      lat = 1;
`else
      q   = (x < 0) ? 1 : -1;
`endif
      r = x;
    end else if (x == -(1 << (N-1)) && y == -1) begin
      q   = -(1 << (N-1));
      r   = 0;
      ovf = 1;
    end else begin
      q = x / y;
      r = x % y;
    end
  endtask

  task automatic waitValid(output int edges);
    edges = -1;
    for (int k = 1; k <= WAIT_MAX; k++) begin
      @(posedge clk);
      #1;
      if (bus.valid === 1'b1) begin
        edges = k;
        break;
      end
    end
  endtask

  // Launch one operation, scramble X/Y after acceptance, return edge count
  // from the accepting edge to the valid pulse (-1 on timeout).
  task automatic applyStimulus(input int x, input int y, output int edges);
    @(negedge clk);
    bus.start = 1'b1;
    bus.X     = 4'(x);
    bus.Y     = 4'(y);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.X     = 4'($urandom);
    bus.Y     = 4'($urandom);
    waitValid(edges);
  endtask

  task automatic checkResult(input string name, input int edges, input int q,
                             input int r, input int ovf, input int dz, input int lat);
    checkOutput({name, ".latency"}, edges, lat);
    checkOutput({name, ".Q"}, $signed(bus.Q), q);
    checkOutput({name, ".R"}, $signed(bus.R), r);
    checkOutput({name, ".ovf"}, {31'd0, bus.ovf}, ovf);
    checkOutput({name, ".dz"}, {31'd0, bus.dz}, dz);
  endtask

  vec_t vecs[13];

  initial begin
    int edges;
    int seen;
    int eq, er, eovf, edz, elat;
    int xi, yi;

    compared   = 0;
    mismatched = 0;
    rst        = 1'b0;
    bus.start  = 1'b0;
    bus.X      = '0;
    bus.Y      = '0;

    vecs[0]  = '{ 7,  2,  3,  1, 0, 0, 5};
    vecs[1]  = '{-7,  2, -3, -1, 0, 0, 5};
    vecs[2]  = '{ 7, -2, -3,  1, 0, 0, 5};
    vecs[3]  = '{-7, -2,  3, -1, 0, 0, 5};
    vecs[4]  = '{-8, -1, -8,  0, 1, 0, 5};
    vecs[5]  = '{-8,  1, -8,  0, 0, 0, 5};
    vecs[6]  = '{ 3,  7,  0,  3, 0, 0, 5};
    vecs[7]  = '{-1, -8,  0, -1, 0, 0, 5};
    vecs[8]  = '{-8, -8,  1,  0, 0, 0, 5};
    vecs[9]  = '{ 6,  3,  2,  0, 0, 0, 5};
`ifdef BOOTH_DIV_DZ_DETECT_EN
    vecs[10] = '{ 5,  0,  0,  5, 0, 1, 1};
    vecs[11] = '{-3,  0,  0, -3, 0, 1, 1};
`else
    vecs[10] = '{ 5,  0, -1,  5, 0, 0, 5};
    vecs[11] = '{-3,  0,  1, -3, 0, 0, 5};
`endif
    vecs[12] = '{-6,  4, -1, -2, 0, 0, 5};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.valid", {31'd0, bus.valid}, 0);
    checkOutput("reset.busy", {31'd0, bus.busy}, 0);
    checkOutput("reset.Q", $signed(bus.Q), 0);
    checkOutput("reset.R", $signed(bus.R), 0);
    checkOutput("reset.ovf", {31'd0, bus.ovf}, 0);
    checkOutput("reset.dz", {31'd0, bus.dz}, 0);
    @(negedge clk);
    rst = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].x, vecs[i].y, edges);
      checkResult($sformatf("vec%0d", i), edges, vecs[i].q, vecs[i].r,
                  vecs[i].ovf, vecs[i].dz, vecs[i].lat);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d.pulse", i), {31'd0, bus.valid}, 0);
      checkOutput($sformatf("vec%0d.hold", i), $signed(bus.Q), vecs[i].q);
    end

    // start pulsed again mid-CALC is ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.X     = 4'(7);
    bus.Y     = 4'(2);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midstart.busy", {31'd0, bus.busy}, 1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.X     = 4'(1);
    bus.Y     = 4'(1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    waitValid(edges);
    checkResult("midstart", edges, 3, 1, 0, 0, N - 1);

    // Reset during CALC aborts the operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.X     = 4'(7);
    bus.Y     = 4'(3);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort.Q", $signed(bus.Q), 0);
    checkOutput("abort.R", $signed(bus.R), 0);
    checkOutput("abort.busy", {31'd0, bus.busy}, 0);
    checkOutput("abort.valid", {31'd0, bus.valid}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    for (int k = 0; k < N + 4; k++) begin
      @(posedge clk);
      #1;
      if (bus.valid === 1'b1) seen++;
    end
    checkOutput("abort.novalid", seen, 0);
    applyStimulus(-6, 4, edges);
    checkResult("after_abort", edges, -1, -2, 0, 0, N + 1);

    // Back-to-back: start held high across valid
    @(negedge clk);
    bus.start = 1'b1;
    bus.X     = 4'(6);
    bus.Y     = 4'(-4);
    @(posedge clk);
    #1;
    waitValid(edges);
    checkResult("b2b.first", edges, -1, 2, 0, 0, N + 1);
    bus.X = 4'(-5);
    bus.Y = 4'(3);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    waitValid(edges);
    checkResult("b2b.second", edges, -1, -2, 0, 0, N + 1);

    // Random operands against the reference model
    for (int i = 0; i < N_RANDOM; i++) begin
      xi = int'($urandom_range(0, 15)) - 8;
      yi = int'($urandom_range(0, 15)) - 8;
      refModel(xi, yi, eq, er, eovf, edz, elat);
      applyStimulus(xi, yi, edges);
      checkResult($sformatf("rand%0d(%0d/%0d)", i, xi, yi), edges, eq, er, eovf, edz, elat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
